// File: rtl/dlx_pkg.sv
// DLX instruction-format constants and field packing shared by the
// instruction encoder and decoder.
package dlx_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_RSV = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQZ    = 6'h04;
  localparam logic [5:0] OP_BNEZ    = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SUBI    = 6'h0A;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam int OP_LSB   = 26;
  localparam int RS1_LSB  = 21;
  localparam int RS2_LSB  = 16;
  localparam int RDR_LSB  = 11;
  localparam int RDI_LSB  = 16;
  localparam int FUNC_LSB = 0;

  typedef logic [31:0] word_t;

  function automatic word_t encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [5:0]  func,
    input logic [25:0] imm
  );
    word_t w;
    w = '0;
    case (1'b1)
      fmt == FMT_R: w = {op, rs1, rs2, rd, 5'b0, func};
      fmt == FMT_I: w = {op, rs1, rd, imm[15:0]};
      fmt == FMT_J: w = {op, imm};
      default:      w = '0;
    endcase
    return w;
  endfunction

  // Logical immediates are zero-extended; the rest sign-extend.
  function automatic logic imm_ok(
    input logic [5:0]  op,
    input logic [25:0] imm
  );
    if (op inside {OP_ANDI, OP_ORI, OP_XORI})
      return imm[25:16] == 10'd0;
    return imm[25:16] == {10{imm[15]}};
  endfunction

endpackage

// File: rtl/dlx_inst_encoder_if.sv
// Field-set input and instruction-memory write bus of the
// DLX instruction encoder.
interface dlx_inst_encoder_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [5:0]        in_op;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [5:0]        in_func;
  logic [25:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  count;
  logic              err;

  modport master (
    output in_valid, in_fmt, in_op,
    output in_rs1, in_rs2, in_rd,
    output in_func, in_imm, mem_ack,
    input  in_ready, mem_we, mem_addr,
    input  mem_wdata, count, err
  );

  modport slave (
    input  in_valid, in_fmt, in_op,
    input  in_rs1, in_rs2, in_rd,
    input  in_func, in_imm, mem_ack,
    output in_ready, mem_we, mem_addr,
    output mem_wdata, count, err
  );
endinterface

// File: rtl/inst_fifo.sv
// Synchronous word FIFO with flush; head reads zero when empty,
// pushes when full and pops when empty are dropped.
module inst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && (cnt_q != FULL);
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign head  = (cnt_q == '0) ? '0 : mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/dlx_inst_encoder.sv
// Packs DLX fields into R/I/J words and streams them to memory.
// Optional I-immediate range check: DLX_INST_ENC_RANGE_CHECK_EN.
module dlx_inst_encoder
  import dlx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input logic              clk,
  input logic              rst,
  input logic              restart,
  dlx_inst_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt;
  word_t             word, head;
  logic              xfer, rsv, push, pop, bad;

  assign bus.in_ready = (cnt != CW'(DEPTH)) && !restart;
  assign xfer = bus.in_valid && bus.in_ready;
  assign rsv  = bus.in_fmt == FMT_RSV;
  assign push = xfer && !rsv;
  assign pop  = bus.mem_we && bus.mem_ack && !restart;

  assign word = encode(bus.in_fmt, bus.in_op,
                       bus.in_rs1, bus.in_rs2, bus.in_rd,
                       bus.in_func, bus.in_imm);

`ifdef DLX_INST_ENC_RANGE_CHECK_EN
  // Out-of-range immediates still go out truncated.
  assign bad = push && (bus.in_fmt == FMT_I)
            && !imm_ok(bus.in_op, bus.in_imm);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    if (restart) begin
      addr_d = BASE;
      err_d  = 1'b0;
    end else begin
      if (pop) addr_d = addr_q + ADDR_W'(1);
      if ((xfer && rsv) || bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  inst_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (restart),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .head  (head),
    .count (cnt)
  );

  assign bus.mem_we    = cnt != '0;
  assign bus.mem_wdata = head;
  assign bus.mem_addr  = addr_q;
  assign bus.count     = cnt;
  assign bus.err       = err_q;

endmodule
